// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline write/flush sequencer for load-use, branch, MDU occupancy and memory waits,
// with sticky memory-timeout flag and saturating stall/flush counters.
module hazard_stall_ctrl #(
    parameter int MDU_LATENCY = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_RegDst,
    input  logic             EX_MduOp,
    input  logic             EX_BranchTaken,
    input  logic             MEM_MemReq,
    input  logic             MEM_MemReady,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Write,
    output logic             EX_MEM_Flush,
    output logic             MEM_WB_Write,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    localparam int MW = MDU_LATENCY > 2 ? $clog2(MDU_LATENCY) : 1;
    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {RUN, MDU_WAIT} state_t;

    state_t        state, state_nxt;
    logic [MW-1:0] mdu_cnt, mdu_nxt;
    logic [TW-1:0] wait_cnt;
    logic          memwait, load_use, mdu_busy, branch;

    assign memwait  = MEM_MemReq && !MEM_MemReady;
    assign load_use = EX_MemRead && EX_RegDst != 5'd0 &&
                      (EX_RegDst == ID_Rs || (ID_UsesRt && EX_RegDst == ID_Rt));
    assign mdu_busy = state == MDU_WAIT && mdu_cnt != '0;

    always_comb begin
        PC_Write     = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Write  = 1'b1;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Write = 1'b1;
        EX_MEM_Flush = 1'b0;
        MEM_WB_Write = 1'b1;
        branch       = 1'b0;
        state_nxt    = state;
        mdu_nxt      = mdu_cnt;
        if (!rst_n) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            IF_ID_Flush  = 1'b1;
            ID_EX_Write  = 1'b0;
            ID_EX_Flush  = 1'b1;
            EX_MEM_Write = 1'b0;
            MEM_WB_Write = 1'b0;
        end else if (memwait) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            mdu_nxt      = mdu_busy ? mdu_cnt - MW'(1) : mdu_cnt;
        end else if (mdu_busy) begin
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Write  = 1'b0;
            EX_MEM_Flush = 1'b1;
            mdu_nxt      = mdu_cnt - MW'(1);
        end else begin
            // An expired MDU_WAIT decodes as RUN with the finished MDU op masked
            state_nxt = RUN;
            if (EX_BranchTaken) begin
                IF_ID_Flush = 1'b1;
                ID_EX_Flush = 1'b1;
                branch      = 1'b1;
            end else if (state == RUN && EX_MduOp && MDU_LATENCY > 1) begin
                PC_Write     = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Write  = 1'b0;
                EX_MEM_Flush = 1'b1;
                state_nxt    = MDU_WAIT;
                mdu_nxt      = MW'(MDU_LATENCY - 2);
            end else if (load_use) begin
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
                ID_EX_Flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            mdu_cnt     <= '0;
            wait_cnt    <= '0;
            mem_error   <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state    <= state_nxt;
            mdu_cnt  <= mdu_nxt;
            wait_cnt <= !memwait ? '0 : wait_cnt == TW'(MEM_TIMEOUT) ? wait_cnt : wait_cnt + TW'(1);
            if (memwait && wait_cnt >= TW'(MEM_TIMEOUT - 1))
                mem_error <= 1'b1;
            if (!PC_Write && !(&stall_count))
                stall_count <= stall_count + CNT_W'(1);
            if (branch && !(&flush_count))
                flush_count <= flush_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed + random stimulus scored against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;
    localparam int LAT = 4;
    localparam int TMO = 15;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    typedef struct packed {
        logic [7:0]    ctl;
        logic          err;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [4:0] ID_Rs = '0, ID_Rt = '0, EX_RegDst = '0;
    logic ID_UsesRt = 0, EX_MemRead = 0, EX_MduOp = 0, EX_BranchTaken = 0, MEM_MemReq = 0, MEM_MemReady = 0;
    logic PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, EX_MEM_Flush, MEM_WB_Write;
    logic mem_error;
    logic [CW-1:0] stall_count, flush_count;
    logic [7:0] ctl;

    int tests = 0, fails = 0;
    exp_t sb[$];
    int mdu_left = 0, wait_run = 0, m_stall = 0, m_flush = 0;
    logic m_err = 0;

    hazard_stall_ctrl #(.MDU_LATENCY(LAT), .MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead), .EX_RegDst(EX_RegDst), .EX_MduOp(EX_MduOp),
        .EX_BranchTaken(EX_BranchTaken), .MEM_MemReq(MEM_MemReq), .MEM_MemReady(MEM_MemReady),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Write(ID_EX_Write), .ID_EX_Flush(ID_EX_Flush), .EX_MEM_Write(EX_MEM_Write),
        .EX_MEM_Flush(EX_MEM_Flush), .MEM_WB_Write(MEM_WB_Write), .mem_error(mem_error),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    assign ctl = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, EX_MEM_Flush, MEM_WB_Write};

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: the DUT presents a fresh output set every cycle; score it mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("ctl", ctl, e.ctl);
            check("mem_error", mem_error, e.err);
            check("stall_count", stall_count, e.sc);
            check("flush_count", flush_count, e.fc);
        end
    end

    // Reference model: mdu_left counts cycles the MDU op still owns EX after its first cycle
    task automatic cyc(input logic rd, input logic [4:0] dst, rs, rt, input logic urt, mdu, br, req, rdy);
        logic mw, lu, rel;
        exp_t e;
        @(posedge clk);
        #2;
        EX_MemRead = rd; EX_RegDst = dst; ID_Rs = rs; ID_Rt = rt; ID_UsesRt = urt;
        EX_MduOp = mdu; EX_BranchTaken = br; MEM_MemReq = req; MEM_MemReady = rdy;
        mw = req && !rdy;
        lu = rd && dst != 0 && (dst == rs || (urt && dst == rt));
        e.err = m_err;
        e.sc = CW'(m_stall);
        e.fc = CW'(m_flush);
        e.ctl = 8'b1101_0101;
        if (mw) begin
            e.ctl = 8'b0000_0001;
            if (mdu_left > 1) mdu_left--;
        end else if (mdu_left > 1) begin
            e.ctl = 8'b0000_0111;
            mdu_left--;
        end else begin
            rel = mdu_left == 1;
            mdu_left = 0;
            if (br) begin
                e.ctl = 8'b1111_1101;
                if (m_flush < SAT) m_flush++;
            end else if (mdu && !rel) begin
                e.ctl = 8'b0000_0111;
                mdu_left = LAT - 1;
            end else if (lu) begin
                e.ctl = 8'b0001_1101;
            end
        end
        if (!e.ctl[7] && m_stall < SAT) m_stall++;
        wait_run = mw ? wait_run + 1 : 0;
        if (wait_run >= TMO) m_err = 1;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_ctl", ctl, 8'b0010_1000);
        check("rst_stall", stall_count, 0);
        check("rst_flush", flush_count, 0);
        check("rst_err", mem_error, 0);
    endtask

    // Drop rst_n between edges, after the pending cycle has been scored
    task automatic reset_mid();
        #4;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        EX_MemRead = 0; EX_MduOp = 0; EX_BranchTaken = 0; MEM_MemReq = 0;
        mdu_left = 0; wait_run = 0; m_stall = 0; m_flush = 0; m_err = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #3;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        cyc(1, 8, 8, 3, 0, 0, 0, 0, 0);
        idle(2);
        cyc(1, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(1);
        cyc(1, 8, 8, 8, 1, 0, 1, 0, 0);
        idle(2);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(5);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(4);
        for (int i = 0; i < TMO; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(3);
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(1);
        reset_mid();
        idle(2);
        for (int i = 0; i < SAT + 4; i++) cyc(1, 5, 5, 0, 0, 0, 0, 0, 0);
        idle(2);
        reset_mid();
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 7) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 1), $urandom_range(0, 3) != 0);
            if (i % 500 == 499) reset_mid();
        end
        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
